io_timer_irq: RTL
=================

# io_timer_irq

Memory-mapped timer and interrupt source on the 4510 CPU bus. It sits beside main memory and drives the CPU `irq` and `nmi` inputs. The CPU programs a 16-bit down-counter with optional auto-reload through four byte registers. Expiry raises a maskable IRQ; software can raise a latched NMI. The bus side uses the CPU's look-ahead address, write strobe and write data, so reads return registered data one cycle later, the same as the synchronous memory.

## Interface
- `BASE` — default 20'h0BFF8 — byte address of register 0; the block decodes `BASE`..`BASE+3`.
- `PRESCALE` — default 4 — clocks per timer tick; legal range 1..256.
- `clk` in 1 — system clock, all state on posedge.
- `reset` in 1 — synchronous, active-high.
- `ready` in 1 — bus ready; bus reads and writes are accepted only when it is high.
- `address_next` in 20 — CPU look-ahead address (`address_next` of cpu4510).
- `write_next` in 1 — CPU look-ahead write strobe.
- `data_i` in 8 — CPU look-ahead write data (`data_o_next`).
- `data_o` out 8 — registered read data.
- `sel` out 1 — registered; high when `data_o` is valid for the current CPU `address`. The system read mux selects `data_o` over memory while `sel` is high.
- `irq` out 1 — level, active-high: `tmr_pend & irq_en`.
- `nmi` out 1 — level, active-high: `nmi_pend`.

## Operation
Register map (offset from `BASE`):
- **+0 CTRL (R/W)**
  - bit0 `run`; bit1 `autoreload`; bit2 `irq_en`.
  - bit3 is write-only: writing 1 sets `nmi_pend`. It reads as 0.
  - bits 7:4 read as 0.
- **+1 STATUS (R/W1C)**
  - bit0 `tmr_pend`; bit1 `nmi_pend`.
  - Writing 1 to a bit clears it; writing 0 has no effect.
- **+2 RELOAD_LO**
  - Write: stores the `reload[7:0]` holding byte.
  - Read: returns `count[7:0]`.
- **+3 RELOAD_HI**
  - Write: stores `reload[15:8]`, then loads `count <= {data_i, reload[7:0]}` and clears the prescaler.
  - Read: returns `count[15:8]`.

Prescaler:
- Counts 0..`PRESCALE`-1 while `run`=1.
- Emits `tick` on the cycle it wraps to 0.
- Is held at 0 while `run`=0.

Counter, on each `tick`:
- `count != 0`: `count <= count - 1`.
- `count == 0` (expiry):
  - Set `tmr_pend`.
  - If `autoreload`: `count <= reload`.
  - Otherwise: clear `run`, `count` stays 0.

Width rules: `count` and `reload` are 16-bit unsigned. A reload of 0 with `autoreload` set expires on every tick.

## Timing
Write acceptance:
- A write is accepted at posedge when `ready & write_next` and `address_next` is in `BASE`..`BASE+3`.
- The register updates at that edge.
- `irq`/`nmi` reflect the new state one cycle later, because they are combinational from registered state.

Read acceptance:
- A read is accepted at posedge when `ready & ~write_next` and the address is in range.
- At that edge `data_o` is loaded and `sel` is set to 1.
- At any other edge, `sel` goes to 0 and `data_o` holds its value.
- Latency is 1 cycle, matching the synchronous memory.

Timer behaviour:
- The timer runs independently of `ready`.
- Counter, prescaler and pending flags keep running during bus stalls.

Simultaneous events:
- Expiry and a W1C of `tmr_pend` in the same cycle: set wins, and `tmr_pend` stays 1.
- CTRL bit3 write and a W1C of `nmi_pend` in the same cycle: set wins.
- RELOAD_HI write and a tick in the same cycle: the write wins. `count` gets the new value and no decrement or expiry occurs.
- CTRL write clearing `run` in the same cycle as expiry: `tmr_pend` still sets, and `run` ends at 0.

Reset (synchronous):
- All registers, prescaler, `count`, `reload`, `tmr_pend` and `nmi_pend` go to 0.
- `data_o` goes to 8'h00; `sel`, `irq` and `nmi` go to 0.
- Reset overrides any same-cycle bus write and any tick.
- Reset mid-countdown stops the timer immediately.

## Test plan
- **Reset values.** Assert `reset` for 2 cycles while `write_next`=1 to `BASE` with 8'hFF. After release: `irq`=0, `nmi`=0, `sel`=0, `data_o`=00; CTRL reads 00.
- **One-shot expiry.** `PRESCALE`=4. Write RELOAD_LO=03, RELOAD_HI=00, then CTRL=05. `irq` must rise exactly 16 clocks after the CTRL write edge. Then CTRL reads 04, count reads 0000. Writing STATUS=01 drops `irq` the next cycle.
- **Auto-reload.** Write reload=0002, then CTRL=07. `tmr_pend` sets every 12 clocks. With `irq_en`=0 (CTRL=03), `tmr_pend` still sets while `irq` stays 0.
- **Set-wins race.** Schedule a STATUS=01 write on the expiry edge. Required: `tmr_pend`=1 and `irq`=1 afterwards.
- **Soft NMI.** Write CTRL=08. `nmi`=1 the next cycle and CTRL reads 00. Writing STATUS=02 clears `nmi`. Writing STATUS=01 leaves `nmi` set.
- **Read path and ready stall.**
  - Read `BASE+3` with count=1234: `data_o`=12 and `sel`=1 one cycle later.
  - With `ready`=0, an access to `BASE+1` leaves `sel`=0 and `data_o` unchanged, and the counter still decrements.

Source files
------------

// File: rtl/io_timer_irq.sv
// io_timer_irq: bus-mapped 16-bit prescaled down-counter with maskable IRQ and soft NMI.
module io_timer_irq #(
  parameter logic [19:0] BASE = 20'h0BFF8,
  parameter int PRESCALE = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ready,
  input  logic [19:0] address_next,
  input  logic        write_next,
  input  logic [7:0]  data_i,
  output logic [7:0]  data_o,
  output logic        sel,
  output logic        irq,
  output logic        nmi
);
  logic run, autoreload, irq_en, tmr_pend, nmi_pend;
  logic [7:0] reload_lo, reload_hi, rdata;
  logic [15:0] count;
  logic [8:0] pre;
  logic [19:0] off;
  logic hit, wr, rd, ctrl_wr, st_wr, lo_wr, hi_wr, tick, expire;
  always_comb begin
    off = address_next - BASE;
    hit = off < 20'd4;
    wr = ready & write_next & hit;
    rd = ready & ~write_next & hit;
    ctrl_wr = wr & (off[1:0] == 2'd0);
    st_wr = wr & (off[1:0] == 2'd1);
    lo_wr = wr & (off[1:0] == 2'd2);
    hi_wr = wr & (off[1:0] == 2'd3);
    tick = run & (pre == 9'(PRESCALE - 1));
    // a RELOAD_HI write pre-empts any same-cycle tick
    expire = tick & ~hi_wr & (count == 16'd0);
    rdata = (off[1:0] == 2'd0) ? {5'b0, irq_en, autoreload, run} :
            (off[1:0] == 2'd1) ? {6'b0, nmi_pend, tmr_pend} :
            (off[1:0] == 2'd2) ? count[7:0] : count[15:8];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      {run, autoreload, irq_en, tmr_pend, nmi_pend, sel} <= '0;
      {reload_lo, reload_hi, count, pre, data_o} <= '0;
    end else begin
      pre <= (~run | hi_wr | tick) ? 9'd0 : pre + 1'b1;
      if (ctrl_wr) {irq_en, autoreload, run} <= data_i[2:0];
      else if (expire & ~autoreload) run <= 1'b0;
      if (lo_wr) reload_lo <= data_i;
      if (hi_wr) begin
        reload_hi <= data_i;
        count <= {data_i, reload_lo};
      end else if (tick) count <= (count != 16'd0) ? count - 1'b1 : autoreload ? {reload_hi, reload_lo} : count;
      tmr_pend <= expire | (tmr_pend & ~(st_wr & data_i[0]));
      nmi_pend <= (ctrl_wr & data_i[3]) | (nmi_pend & ~(st_wr & data_i[1]));
      sel <= rd;
      if (rd) data_o <= rdata;
    end
  end
  assign irq = tmr_pend & irq_en;
  assign nmi = nmi_pend;
endmodule
